// File: rtl/wb_regfile_if.sv
// Writeback/register-file bus between the MEM/WB side and the decode-side read ports.
// Latency: none, plain wires. Backpressure: none; init_busy_o tells the pipeline to stall.
// Port names match the register file's documented pin names.
interface wb_regfile_if #(
    parameter int PROC_DATA_WIDTH        = 16,
    parameter int PROC_REGFILE_LOG2_DEEP = 5
);
    logic                              reg_write_en_i;
    logic                              mem_to_reg_i;
    logic [PROC_REGFILE_LOG2_DEEP-1:0] reg_write_addr_i;
    logic [PROC_DATA_WIDTH-1:0]        alu_i;
    logic [PROC_DATA_WIDTH-1:0]        mem_rdata_i;
    logic [PROC_REGFILE_LOG2_DEEP-1:0] rd_addr_a_i;
    logic [PROC_REGFILE_LOG2_DEEP-1:0] rd_addr_b_i;
    logic [PROC_DATA_WIDTH-1:0]        rd_data_a_o;
    logic [PROC_DATA_WIDTH-1:0]        rd_data_b_o;
    logic [PROC_DATA_WIDTH-1:0]        wb_data_o;
    logic                              init_busy_o;

    modport master (
        output reg_write_en_i, mem_to_reg_i, reg_write_addr_i, alu_i, mem_rdata_i,
               rd_addr_a_i, rd_addr_b_i,
        input  rd_data_a_o, rd_data_b_o, wb_data_o, init_busy_o
    );

    modport slave (
        input  reg_write_en_i, mem_to_reg_i, reg_write_addr_i, alu_i, mem_rdata_i,
               rd_addr_a_i, rd_addr_b_i,
        output rd_data_a_o, rd_data_b_o, wb_data_o, init_busy_o
    );
endinterface

// File: rtl/wb_regfile.sv
// Writeback mux plus architectural register file with a post-reset self-clear (CLEAR -> RUN).
// Latency: writes land at the clock edge, reads are combinational; WB_BYPASS_EN adds same-cycle write forwarding.
// Backpressure: init_busy_o is high for DEEP cycles after reset; writes are dropped while it is high.
module wb_regfile #(
    parameter int PROC_DATA_WIDTH        = 16,
    parameter int PROC_REGFILE_LOG2_DEEP = 5
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    wb_regfile_if.slave   bus
);
    localparam int DEEP = 2 ** PROC_REGFILE_LOG2_DEEP;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                            state;
    logic [PROC_REGFILE_LOG2_DEEP-1:0] clr_idx;
    logic                              init_busy;
    logic [PROC_DATA_WIDTH-1:0]        regs [DEEP];
    logic [PROC_DATA_WIDTH-1:0]        wb_data;
    logic                              wr_hit;
    logic [PROC_DATA_WIDTH-1:0]        rd_a;
    logic [PROC_DATA_WIDTH-1:0]        rd_b;

    assign wb_data = bus.mem_to_reg_i ? bus.mem_rdata_i : bus.alu_i;
    assign wr_hit  = bus.reg_write_en_i && (bus.reg_write_addr_i != '0);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state     <= ST_CLEAR;
            clr_idx   <= '0;
            init_busy <= 1'b1;
        end else begin
            case (state)
                ST_CLEAR: begin
                    regs[clr_idx] <= '0;
                    clr_idx       <= clr_idx + 1'b1;
                    if (clr_idx == PROC_REGFILE_LOG2_DEEP'(DEEP - 1)) begin
                        state     <= ST_RUN;
                        init_busy <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (wr_hit) begin
                        regs[bus.reg_write_addr_i] <= wb_data;
                    end
                end
                default: begin
                    state     <= ST_CLEAR;
                    clr_idx   <= '0;
                    init_busy <= 1'b1;
                end
            endcase
        end
    end

    // Reads of index 0, and all reads during reset or CLEAR, return zero.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if (rst_n_i && (state == ST_RUN)) begin
            if (bus.rd_addr_a_i != '0) begin
                rd_a = regs[bus.rd_addr_a_i];
            end
            if (bus.rd_addr_b_i != '0) begin
                rd_b = regs[bus.rd_addr_b_i];
            end
`ifdef WB_BYPASS_EN
            if (wr_hit && (bus.reg_write_addr_i == bus.rd_addr_a_i)) begin
                rd_a = wb_data;
            end
            if (wr_hit && (bus.reg_write_addr_i == bus.rd_addr_b_i)) begin
                rd_b = wb_data;
            end
`else
`endif
        end
    end

    assign bus.wb_data_o   = wb_data;
    assign bus.rd_data_a_o = rd_a;
    assign bus.rd_data_b_o = rd_b;
    assign bus.init_busy_o = init_busy;
endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus random traffic against an array model.
module tb_wb_regfile;
    localparam int DW   = 16;
    localparam int AW   = 5;
    localparam int DEEP = 32;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic rst_n_i;
    always #5 clk_i = ~clk_i;

    wb_regfile_if #(.PROC_DATA_WIDTH(DW), .PROC_REGFILE_LOG2_DEEP(AW)) bus ();

    wb_regfile #(.PROC_DATA_WIDTH(DW), .PROC_REGFILE_LOG2_DEEP(AW)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    int          vectors    = 0;
    int          miscompares = 0;
    logic [DW-1:0] model [DEEP];
    bit          m_busy;
    int          m_left;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic rst, input logic we,
                                              input logic [AW-1:0] wa, input logic [DW-1:0] wb,
                                              input logic [AW-1:0] ra);
        if (!rst || m_busy || ra == 0) return '0;
        if (BYP && we && wa != 0 && wa == ra) return wb;
        return model[ra];
    endfunction

    // One clock: drive, check combinational outputs before the edge, then advance the model.
    task automatic step(input logic rst, input logic we, input logic m2r, input logic [AW-1:0] wa,
                        input logic [DW-1:0] alu, input logic [DW-1:0] mrd,
                        input logic [AW-1:0] ra, input logic [AW-1:0] rb, input string tag);
        logic [DW-1:0] wb;
        wb = m2r ? mrd : alu;
        rst_n_i              = rst;
        bus.reg_write_en_i   = we;
        bus.mem_to_reg_i     = m2r;
        bus.reg_write_addr_i = wa;
        bus.alu_i            = alu;
        bus.mem_rdata_i      = mrd;
        bus.rd_addr_a_i      = ra;
        bus.rd_addr_b_i      = rb;
        #2;
        check({tag, ".wb"},   bus.wb_data_o, wb);
        check({tag, ".rda"},  bus.rd_data_a_o, exp_rd(rst, we, wa, wb, ra));
        check({tag, ".rdb"},  bus.rd_data_b_o, exp_rd(rst, we, wa, wb, rb));
        check({tag, ".busy"}, {15'd0, bus.init_busy_o}, {15'd0, m_busy});
        @(posedge clk_i);
        #1;
        if (!rst) begin
            m_busy = 1'b1;
            m_left = DEEP;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                for (int i = 0; i < DEEP; i++) model[i] = '0;
            end
        end else if (we && wa != 0) begin
            model[wa] = wb;
        end
    endtask

    task automatic rand_step(input logic rst, input string tag);
        logic [AW-1:0] wa;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        wa = AW'($urandom_range(DEEP - 1));
        ra = ($urandom_range(3) == 0) ? wa : AW'($urandom_range(DEEP - 1));
        rb = ($urandom_range(3) == 0) ? wa : AW'($urandom_range(DEEP - 1));
        step(rst, 1'($urandom_range(1)), 1'($urandom_range(1)), wa,
             DW'($urandom), DW'($urandom), ra, rb, tag);
    endtask

    initial begin
        for (int i = 0; i < DEEP; i++) model[i] = '0;
        rst_n_i              = 1'b0;
        bus.reg_write_en_i   = 1'b0;
        bus.mem_to_reg_i     = 1'b0;
        bus.reg_write_addr_i = '0;
        bus.alu_i            = '0;
        bus.mem_rdata_i      = '0;
        bus.rd_addr_a_i      = '0;
        bus.rd_addr_b_i      = '0;
        @(posedge clk_i);
        #1;
        m_busy = 1'b1;
        m_left = DEEP;
        check("reset.busy", {15'd0, bus.init_busy_o}, 16'd1);
        check("reset.rda", bus.rd_data_a_o, 16'h0000);

        // CLEAR: a write to entry 4 must be ignored, reads forced to zero.
        step(1'b1, 1'b1, 1'b0, 5'd4, 16'h5555, 16'h0000, 5'd4, 5'd4, "clr_wr4");
        for (int i = 1; i < DEEP; i++) rand_step(1'b1, "clear");
        check("clear_done.busy", {15'd0, bus.init_busy_o}, 16'd0);

        for (int i = 0; i < DEEP; i++)
            step(1'b1, 1'b0, 1'b0, 5'd0, 16'h0, 16'h0, AW'(i), AW'(DEEP - 1 - i), "read_zero");

        step(1'b1, 1'b1, 1'b0, 5'd5, 16'h1234, 16'h0000, 5'd5, 5'd0, "wr5");
        step(1'b1, 1'b0, 1'b0, 5'd0, 16'h0000, 16'h0000, 5'd5, 5'd5, "rd5");
        check("rd5.direct", bus.rd_data_a_o, 16'h1234);
        step(1'b1, 1'b1, 1'b1, 5'd7, 16'h1111, 16'hBEEF, 5'd1, 5'd2, "wr7");
        step(1'b1, 1'b1, 1'b0, 5'd0, 16'hFFFF, 16'h0000, 5'd7, 5'd0, "wr0");
        step(1'b1, 1'b0, 1'b0, 5'd0, 16'h0000, 16'h0000, 5'd0, 5'd7, "rd0_7");
        check("rd7.direct", bus.rd_data_b_o, 16'hBEEF);
        check("rd0.direct", bus.rd_data_a_o, 16'h0000);
        step(1'b1, 1'b1, 1'b0, 5'd3, 16'h00FF, 16'h0000, 5'd3, 5'd3, "wr3");

        step(1'b1, 1'b1, 1'b0, 5'd9, 16'hA5A5, 16'h0000, 5'd9, 5'd9, "same9");
        step(1'b1, 1'b0, 1'b0, 5'd0, 16'h0000, 16'h0000, 5'd9, 5'd9, "after9");
        check("after9.direct", bus.rd_data_a_o, 16'hA5A5);

        for (int i = 0; i < 200; i++) rand_step(1'b1, "run_rand");
        step(1'b1, 1'b1, 1'b0, 5'd3, 16'h00FF, 16'h0000, 5'd3, 5'd0, "rewr3");

        // Reset from RUN, then again at clear cycle 10.
        rand_step(1'b0, "rst_run");
        for (int i = 0; i < 10; i++) rand_step(1'b1, "clear_a");
        rand_step(1'b0, "rst_mid_clear");
        for (int i = 0; i < DEEP - 1; i++) rand_step(1'b1, "clear_b");
        check("pre_done.busy", {15'd0, bus.init_busy_o}, 16'd1);
        rand_step(1'b1, "clear_last");
        check("restart_done.busy", {15'd0, bus.init_busy_o}, 16'd0);
        step(1'b1, 1'b0, 1'b0, 5'd0, 16'h0, 16'h0, 5'd3, 5'd4, "rd3_4");
        check("rd3.direct", bus.rd_data_a_o, 16'h0000);

        for (int i = 0; i < 150; i++) rand_step(1'b1, "run_rand2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
